div_4bit_seq: RTL and testbench



---
 rtl/div_4bit_seq_if.sv | 27 ++
 rtl/div_4bit_seq.sv | 105 ++++++++++
 tb/tb_div_4bit_seq.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/div_4bit_seq_if.sv
// Handshake and adder-operand bundle between the divider, its controller and
// the external add_sub_4bit.
interface div_4bit_seq_if;
  logic       start;
  logic [3:0] dividend;
  logic [3:0] divisor;
  logic [3:0] sub_a;
  logic [3:0] sub_b;
  logic       sub_k;
  logic [3:0] sub_s;
  logic       sub_cout;
  logic       busy;
  logic       done;
  logic [3:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;

  modport slave (
    input  start, dividend, divisor, sub_s, sub_cout,
    output sub_a, sub_b, sub_k, busy, done, quotient, remainder, div_by_zero
  );

  modport master (
    output start, dividend, divisor, sub_s, sub_cout,
    input  sub_a, sub_b, sub_k, busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/div_4bit_seq.sv
// Sequential 4-bit unsigned restoring divider; each trial subtraction is done
// by an external combinational add_sub_4bit driven through sub_a/sub_b/sub_k.
module div_4bit_seq #(
  parameter logic [3:0] ZERO_Q = 4'hF
) (
  input logic            clk,
  input logic            rst,
  div_4bit_seq_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

  state_t     state;
  logic [3:0] q_reg;
  logic [3:0] r_reg;
  logic [3:0] d_reg;
  logic [1:0] count;
  logic       busy;
  logic       done;
  logic [3:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;

  logic [3:0] trial;
  logic [3:0] q_next;
  logic [3:0] r_next;

  // Partial remainder stays below 2^i before iteration i, so 4 bits hold T.
  always_comb begin
    trial  = {r_reg[2:0], q_reg[3]};
    q_next = {q_reg[2:0], 1'b0};
    r_next = trial;
    if (bus.sub_cout) begin
      q_next = {q_reg[2:0], 1'b1};
      r_next = bus.sub_s;
    end
  end

  assign bus.sub_a       = trial;
  assign bus.sub_b       = d_reg;
  assign bus.sub_k       = 1'b1;
  assign bus.busy        = busy;
  assign bus.done        = done;
  assign bus.quotient    = quotient;
  assign bus.remainder   = remainder;
  assign bus.div_by_zero = div_by_zero;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      q_reg       <= '0;
      r_reg       <= '0;
      d_reg       <= '0;
      count       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done  <= 1'b0;
          state <= IDLE;
          if (bus.start) begin
            q_reg       <= bus.dividend;
            d_reg       <= bus.divisor;
            r_reg       <= '0;
            count       <= '0;
            div_by_zero <= 1'b0;
            if (bus.divisor == 4'd0) begin
              state       <= DONE;
              done        <= 1'b1;
              busy        <= 1'b0;
              quotient    <= ZERO_Q;
              remainder   <= bus.dividend;
              div_by_zero <= 1'b1;
            end else begin
              state <= ITER;
              busy  <= 1'b1;
            end
          end
        end
        ITER: begin
          q_reg <= q_next;
          r_reg <= r_next;
          count <= count + 2'd1;
          if (count == 2'd3) begin
            state     <= DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            quotient  <= q_next;
            remainder <= r_next;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_4bit_seq.sv
// Self-checking bench for div_4bit_seq with a behavioural add_sub_4bit and a
// result scoreboard filled at each accepted start.
module tb_div_4bit_seq;

  logic clk;
  logic rst;

  div_4bit_seq_if bus ();

  div_4bit_seq #(.ZERO_Q(4'hF)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Combinational adder/subtractor standing in for add_sub_4bit.
  logic [4:0] add_res;
  assign add_res      = {1'b0, bus.sub_a} + {1'b0, (bus.sub_k ? ~bus.sub_b : bus.sub_b)} + {4'd0, bus.sub_k};
  assign bus.sub_s    = add_res[3:0];
  assign bus.sub_cout = add_res[4];

  typedef struct {
    logic [3:0] q;
    logic [3:0] r;
    logic       dz;
  } exp_t;

  exp_t sb[$];
  int   vectors;
  int   miscompares;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t model(input logic [3:0] a, input logic [3:0] b);
    exp_t e;
    if (b == 4'd0) begin
      e.q  = 4'hF;
      e.r  = a;
      e.dz = 1'b1;
    end else begin
      e.q  = a / b;
      e.r  = a % b;
      e.dz = 1'b0;
    end
    return e;
  endfunction

  // Result monitor: every done pulse must match the oldest outstanding start.
  always @(posedge clk) begin
    #1;
    if (bus.done === 1'b1) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_done: got done=1 q=%0d r=%0d, required no done pulse", bus.quotient, bus.remainder);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (bus.quotient !== e.q || bus.remainder !== e.r || bus.div_by_zero !== e.dz) begin
          miscompares++;
          $display("FAIL result: got q=%0d r=%0d dz=%b, required q=%0d r=%0d dz=%b",
                   bus.quotient, bus.remainder, bus.div_by_zero, e.q, e.r, e.dz);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [3:0] a, input logic [3:0] b);
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    sb.push_back(model(a, b));
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (bus.done !== 1'b1 && n < 12) begin
      tick();
      n++;
    end
    vectors++;
    if (bus.done !== 1'b1) begin
      miscompares++;
      $display("FAIL %s_timeout: got done=%b after %0d cycles, required done=1", name, bus.done, n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0;
    bus.dividend = '0;
    bus.divisor = '0;
    tick();
    tick();
    vectors++;
    if ({bus.busy, bus.done, bus.div_by_zero, bus.quotient, bus.remainder} !== 11'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got busy=%b done=%b dz=%b q=%0d r=%0d, required all 0",
               bus.busy, bus.done, bus.div_by_zero, bus.quotient, bus.remainder);
    end
    vectors++;
    if (bus.sub_k !== 1'b1 || bus.sub_b !== 4'd0) begin
      miscompares++;
      $display("FAIL reset_adder_ops: got sub_k=%b sub_b=%0d, required sub_k=1 sub_b=0", bus.sub_k, bus.sub_b);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    launch(4'd13, 4'd3);
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.sub_k !== 1'b1 || bus.sub_b !== 4'd3) begin
        miscompares++;
        $display("FAIL basic_iter%0d: got busy=%b done=%b sub_k=%b sub_b=%0d, required 1 0 1 3",
                 i, bus.busy, bus.done, bus.sub_k, bus.sub_b);
      end
      tick();
    end
    vectors++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.quotient !== 4'd4 || bus.remainder !== 4'd1 || bus.div_by_zero !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_done: got done=%b busy=%b q=%0d r=%0d dz=%b, required 1 0 4 1 0",
               bus.done, bus.busy, bus.quotient, bus.remainder, bus.div_by_zero);
    end
    tick();
    vectors++;
    if (bus.done !== 1'b0 || bus.sub_k !== 1'b1) begin
      miscompares++;
      $display("FAIL basic_pulse: got done=%b sub_k=%b, required done=0 sub_k=1", bus.done, bus.sub_k);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 256; i++) begin
      logic [7:0] v;
      v = 8'(i);
      launch(v[7:4], v[3:0]);
      wait_done("sweep");
    end
    tick();
    tick();
  endtask

  task automatic test_edges();
    launch(4'd9, 4'd0);
    vectors++;
    if (bus.done !== 1'b1 || bus.quotient !== 4'hF || bus.remainder !== 4'd9 || bus.div_by_zero !== 1'b1) begin
      miscompares++;
      $display("FAIL div_zero: got done=%b q=%0d r=%0d dz=%b, required 1 15 9 1",
               bus.done, bus.quotient, bus.remainder, bus.div_by_zero);
    end
    tick();
    launch(4'd7, 4'd9);
    repeat (4) tick();
    vectors++;
    if (bus.done !== 1'b1 || bus.quotient !== 4'd0 || bus.remainder !== 4'd7 || bus.div_by_zero !== 1'b0) begin
      miscompares++;
      $display("FAIL small_dividend: got done=%b q=%0d r=%0d dz=%b, required 1 0 7 0",
               bus.done, bus.quotient, bus.remainder, bus.div_by_zero);
    end
    tick();
    launch(4'd15, 4'd1);
    repeat (4) tick();
    vectors++;
    if (bus.done !== 1'b1 || bus.quotient !== 4'd15 || bus.remainder !== 4'd0) begin
      miscompares++;
      $display("FAIL div_by_one: got done=%b q=%0d r=%0d, required 1 15 0", bus.done, bus.quotient, bus.remainder);
    end
    tick();
  endtask

  task automatic test_ignore_start();
    launch(4'd15, 4'd15);
    tick();
    bus.start    = 1'b1;
    bus.dividend = 4'd2;
    bus.divisor  = 4'd1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    vectors++;
    if (bus.done !== 1'b1 || bus.quotient !== 4'd1 || bus.remainder !== 4'd0) begin
      miscompares++;
      $display("FAIL ignore_start: got done=%b q=%0d r=%0d, required 1 1 0", bus.done, bus.quotient, bus.remainder);
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      vectors++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
        miscompares++;
        $display("FAIL ignore_extra%0d: got done=%b busy=%b, required 0 0", i, bus.done, bus.busy);
      end
    end
  endtask

  task automatic test_reset_mid();
    launch(4'd14, 4'd5);
    tick();
    tick();
    rst = 1'b1;
    sb.delete();
    tick();
    rst = 1'b0;
    vectors++;
    if ({bus.busy, bus.done, bus.div_by_zero, bus.quotient, bus.remainder} !== 11'd0) begin
      miscompares++;
      $display("FAIL reset_mid: got busy=%b done=%b dz=%b q=%0d r=%0d, required all 0",
               bus.busy, bus.done, bus.div_by_zero, bus.quotient, bus.remainder);
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      vectors++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_discard%0d: got done=%b busy=%b, required 0 0", i, bus.done, bus.busy);
      end
    end
    launch(4'd14, 4'd5);
    wait_done("after_reset");
    vectors++;
    if (bus.quotient !== 4'd2 || bus.remainder !== 4'd4) begin
      miscompares++;
      $display("FAIL after_reset: got q=%0d r=%0d, required 2 4", bus.quotient, bus.remainder);
    end
    tick();
  endtask

  task automatic test_hold();
    launch(4'd10, 4'd4);
    wait_done("hold");
    vectors++;
    if (bus.quotient !== 4'd2 || bus.remainder !== 4'd2 || bus.div_by_zero !== 1'b0) begin
      miscompares++;
      $display("FAIL hold_result: got q=%0d r=%0d dz=%b, required 2 2 0", bus.quotient, bus.remainder, bus.div_by_zero);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      vectors++;
      if (bus.quotient !== 4'd2 || bus.remainder !== 4'd2 || bus.done !== 1'b0 || bus.div_by_zero !== 1'b0) begin
        miscompares++;
        $display("FAIL hold%0d: got q=%0d r=%0d done=%b dz=%b, required 2 2 0 0",
                 i, bus.quotient, bus.remainder, bus.done, bus.div_by_zero);
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    bus.start   = 1'b0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_edges();
    test_ignore_start();
    test_reset_mid();
    test_hold();
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d outstanding results, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
